// File: rtl/multicycle_control_if.sv
// ============================================================================
// Module   : multicycle_control_if
// Brief    : Opcode/handshake inputs and datapath control outputs of the
//            multi-cycle MIPS sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface multicycle_control_if #(
    parameter int ALUOP_W = 4
);
    logic [5:0]         op;
    logic               mem_ready;
    logic               pc_write;
    logic               pc_write_cond;
    logic               pc_write_ncond;
    logic               iord;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               reg_write;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               jal;
    logic               ui;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [ALUOP_W-1:0] alu_op;
    logic [1:0]         pc_source;
    logic               illegal;
    logic [3:0]         state;

    modport master (
        input  op, mem_ready,
        output pc_write, pc_write_cond, pc_write_ncond, iord, mem_read, mem_write,
               ir_write, reg_write, reg_dst, mem_to_reg, jal, ui, alu_src_a,
               alu_src_b, alu_op, pc_source, illegal, state
    );

    modport slave (
        output op, mem_ready,
        input  pc_write, pc_write_cond, pc_write_ncond, iord, mem_read, mem_write,
               ir_write, reg_write, reg_dst, mem_to_reg, jal, ui, alu_src_a,
               alu_src_b, alu_op, pc_source, illegal, state
    );
endinterface

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// Module   : multicycle_control
// Brief    : Moore sequencer for the shared-memory multi-cycle MIPS datapath.
//            Define MULTICYCLE_CONTROL_STALL_EN to honour the mem_ready wait.
// Revision : 1.0
// ============================================================================
`default_nettype none

module multicycle_control #(
    parameter int ALUOP_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_control_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_RWB    = 4'd7,
        S_IEXEC  = 4'd8,  S_IWB    = 4'd9,  S_BRANCH = 4'd10, S_JUMP   = 4'd11,
        S_JAL    = 4'd12
    } state_t;

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_j     = 6'b000010;
    localparam logic [5:0] c_op_jal   = 6'b000011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_bne   = 6'b000101;
    localparam logic [5:0] c_op_addiu = 6'b001001;
    localparam logic [5:0] c_op_slti  = 6'b001010;
    localparam logic [5:0] c_op_sltiu = 6'b001011;
    localparam logic [5:0] c_op_andi  = 6'b001100;
    localparam logic [5:0] c_op_ori   = 6'b001101;
    localparam logic [5:0] c_op_xori  = 6'b001110;
    localparam logic [5:0] c_op_lui   = 6'b001111;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;

    localparam logic [3:0] c_alu_add   = 4'b0000;
    localparam logic [3:0] c_alu_sub   = 4'b0001;
    localparam logic [3:0] c_alu_funct = 4'b0010;
    localparam logic [3:0] c_alu_lui   = 4'b0011;
    localparam logic [3:0] c_alu_slt   = 4'b0100;
    localparam logic [3:0] c_alu_and   = 4'b0101;
    localparam logic [3:0] c_alu_or    = 4'b0110;
    localparam logic [3:0] c_alu_xor   = 4'b0111;
    localparam logic [3:0] c_alu_sltu  = 4'b1001;

    state_t     r_state;
    logic       w_ready;
    logic       w_imm_ui;
    logic [3:0] w_imm_alu;
    logic [3:0] w_alu_op;

`ifdef MULTICYCLE_CONTROL_STALL_EN
    assign w_ready = bus.mem_ready;
`else
    // Handshake disabled: every memory access completes in a single cycle.
    assign w_ready = bus.mem_ready | 1'b1;
`endif

    always_comb begin
        w_imm_alu = c_alu_add;
        w_imm_ui  = 1'b0;
        case (bus.op)
            c_op_lui:   w_imm_alu = c_alu_lui;
            c_op_addiu: begin w_imm_alu = c_alu_add;  w_imm_ui = 1'b1; end
            c_op_andi:  begin w_imm_alu = c_alu_and;  w_imm_ui = 1'b1; end
            c_op_ori:   begin w_imm_alu = c_alu_or;   w_imm_ui = 1'b1; end
            c_op_xori:  begin w_imm_alu = c_alu_xor;  w_imm_ui = 1'b1; end
            c_op_slti:  w_imm_alu = c_alu_slt;
            c_op_sltiu: begin w_imm_alu = c_alu_sltu; w_imm_ui = 1'b1; end
            default:    ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:  if (w_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    case (bus.op)
                        c_op_lw, c_op_sw:                    r_state <= S_MEMADR;
                        c_op_rtype:                          r_state <= S_EXEC;
                        c_op_lui, c_op_addiu, c_op_andi, c_op_ori,
                        c_op_xori, c_op_slti, c_op_sltiu:    r_state <= S_IEXEC;
                        c_op_beq, c_op_bne:                  r_state <= S_BRANCH;
                        c_op_j:                              r_state <= S_JUMP;
                        c_op_jal:                            r_state <= S_JAL;
                        default:                             r_state <= S_FETCH;
                    endcase
                end
                S_MEMADR: r_state <= (bus.op == c_op_sw) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  if (w_ready) r_state <= S_MEMWB;
                S_MEMWR:  if (w_ready) r_state <= S_FETCH;
                S_EXEC:   r_state <= S_RWB;
                S_IEXEC:  r_state <= S_IWB;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    // Outputs are pure decode; reset gates them so an aborted access never completes.
    always_comb begin
        bus.pc_write       = 1'b0;
        bus.pc_write_cond  = 1'b0;
        bus.pc_write_ncond = 1'b0;
        bus.iord           = 1'b0;
        bus.mem_read       = 1'b0;
        bus.mem_write      = 1'b0;
        bus.ir_write       = 1'b0;
        bus.reg_write      = 1'b0;
        bus.reg_dst        = 1'b0;
        bus.mem_to_reg     = 1'b0;
        bus.jal            = 1'b0;
        bus.ui             = 1'b0;
        bus.alu_src_a      = 1'b0;
        bus.alu_src_b      = 2'b00;
        bus.pc_source      = 2'b00;
        bus.illegal        = 1'b0;
        w_alu_op           = c_alu_add;
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    bus.mem_read  = 1'b1;
                    bus.alu_src_b = 2'b01;
                    bus.ir_write  = w_ready;
                    bus.pc_write  = w_ready;
                end
                S_DECODE: begin
                    bus.alu_src_b = 2'b11;
                    case (bus.op)
                        c_op_lw, c_op_sw, c_op_rtype, c_op_lui, c_op_addiu,
                        c_op_andi, c_op_ori, c_op_xori, c_op_slti, c_op_sltiu,
                        c_op_beq, c_op_bne, c_op_j, c_op_jal: bus.illegal = 1'b0;
                        default:                               bus.illegal = 1'b1;
                    endcase
                end
                S_MEMADR: begin bus.alu_src_a = 1'b1; bus.alu_src_b = 2'b10; end
                S_MEMRD:  begin bus.mem_read  = 1'b1; bus.iord = 1'b1; end
                S_MEMWB:  begin bus.reg_write = 1'b1; bus.mem_to_reg = 1'b1; end
                S_MEMWR:  begin bus.mem_write = 1'b1; bus.iord = 1'b1; end
                S_EXEC:   begin bus.alu_src_a = 1'b1; w_alu_op = c_alu_funct; end
                S_RWB:    begin bus.reg_write = 1'b1; bus.reg_dst = 1'b1; end
                S_IEXEC: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'b10;
                    w_alu_op      = w_imm_alu;
                    bus.ui        = w_imm_ui;
                end
                S_IWB:    begin bus.reg_write = 1'b1; bus.ui = w_imm_ui; end
                S_BRANCH: begin
                    bus.alu_src_a      = 1'b1;
                    w_alu_op           = c_alu_sub;
                    bus.pc_source      = 2'b01;
                    bus.pc_write_cond  = (bus.op == c_op_beq);
                    bus.pc_write_ncond = (bus.op == c_op_bne);
                end
                S_JUMP:   begin bus.pc_write = 1'b1; bus.pc_source = 2'b10; end
                S_JAL: begin
                    bus.pc_write  = 1'b1;
                    bus.pc_source = 2'b10;
                    bus.reg_write = 1'b1;
                    bus.jal       = 1'b1;
                end
                default:  ;
            endcase
        end
    end

    assign bus.alu_op = ALUOP_W'(w_alu_op);
    assign bus.state  = rst ? 4'd0 : r_state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-route model plus directed sequences,
// run on a 4-bit and a 6-bit alu_op instance side by side.
`default_nettype none

module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op = 6'd0;
    logic       mem_ready = 1'b1;
    int         n_tests = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    multicycle_control_if #(.ALUOP_W(4)) bus4 ();
    multicycle_control_if #(.ALUOP_W(6)) bus6 ();
    assign bus4.op = op;
    assign bus4.mem_ready = mem_ready;
    assign bus6.op = op;
    assign bus6.mem_ready = mem_ready;

    multicycle_control #(.ALUOP_W(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    multicycle_control #(.ALUOP_W(6)) dut6 (.clk(clk), .rst(rst), .bus(bus6));

    typedef struct packed {
        logic [3:0] state;
        logic [5:0] alu_op;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic pc_write, pc_write_cond, pc_write_ncond, iord, mem_read, mem_write, ir_write;
        logic reg_write, reg_dst, mem_to_reg, jal, ui, alu_src_a, illegal;
    } outs_t;

    logic rdy_eff;
`ifdef MULTICYCLE_CONTROL_STALL_EN
    assign rdy_eff = mem_ready;
`else
    assign rdy_eff = 1'b1;
`endif

    // Route after DECODE: {count, up to three states, first state in low nibble}.
    function automatic logic [13:0] route(input logic [5:0] o);
        case (o)
            6'h23:                         return {2'd3, 4'd4, 4'd3, 4'd2};
            6'h2B:                         return {2'd2, 4'd0, 4'd5, 4'd2};
            6'h00:                         return {2'd2, 4'd0, 4'd7, 4'd6};
            6'h09, 6'h0A, 6'h0B, 6'h0C,
            6'h0D, 6'h0E, 6'h0F:           return {2'd2, 4'd0, 4'd9, 4'd8};
            6'h04, 6'h05:                  return {2'd1, 4'd0, 4'd0, 4'd10};
            6'h02:                         return {2'd1, 4'd0, 4'd0, 4'd11};
            6'h03:                         return {2'd1, 4'd0, 4'd0, 4'd12};
            default:                       return 14'd0;
        endcase
    endfunction

    function automatic logic [5:0] imm_alu(input logic [5:0] o);
        case (o)
            6'h0F: return 6'd3;
            6'h0C: return 6'd5;
            6'h0D: return 6'd6;
            6'h0E: return 6'd7;
            6'h0A: return 6'd4;
            6'h0B: return 6'd9;
            default: return 6'd0;
        endcase
    endfunction

    function automatic logic is_ui(input logic [5:0] o);
        return (o == 6'h09) || (o == 6'h0C) || (o == 6'h0D) || (o == 6'h0E) || (o == 6'h0B);
    endfunction

    function automatic outs_t exp_out(input logic r, input logic [3:0] s, input logic [5:0] o,
                                      input logic rdy);
        outs_t e;
        logic [13:0] rt;
        e = '0;
        rt = route(o);
        if (r) return e;
        e.state = s;
        case (s)
            4'd0:  begin e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = rdy; e.pc_write = rdy; end
            4'd1:  begin e.alu_src_b = 2'b11; e.illegal = (rt[13:12] == 2'd0); end
            4'd2:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            4'd3:  begin e.mem_read = 1; e.iord = 1; end
            4'd4:  begin e.reg_write = 1; e.mem_to_reg = 1; end
            4'd5:  begin e.mem_write = 1; e.iord = 1; end
            4'd6:  begin e.alu_src_a = 1; e.alu_op = 6'd2; end
            4'd7:  begin e.reg_write = 1; e.reg_dst = 1; end
            4'd8:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_op = imm_alu(o); e.ui = is_ui(o); end
            4'd9:  begin e.reg_write = 1; e.ui = is_ui(o); end
            4'd10: begin
                e.alu_src_a = 1; e.alu_op = 6'd1; e.pc_source = 2'b01;
                e.pc_write_cond = (o == 6'h04); e.pc_write_ncond = (o == 6'h05);
            end
            4'd11: begin e.pc_write = 1; e.pc_source = 2'b10; end
            4'd12: begin e.pc_write = 1; e.pc_source = 2'b10; e.reg_write = 1; e.jal = 1; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic outs_t sample4();
        outs_t s;
        s = {bus4.state, 2'b00, bus4.alu_op, bus4.alu_src_b, bus4.pc_source, bus4.pc_write,
             bus4.pc_write_cond, bus4.pc_write_ncond, bus4.iord, bus4.mem_read, bus4.mem_write,
             bus4.ir_write, bus4.reg_write, bus4.reg_dst, bus4.mem_to_reg, bus4.jal, bus4.ui,
             bus4.alu_src_a, bus4.illegal};
        return s;
    endfunction

    function automatic outs_t sample6();
        outs_t s;
        s = {bus6.state, bus6.alu_op, bus6.alu_src_b, bus6.pc_source, bus6.pc_write,
             bus6.pc_write_cond, bus6.pc_write_ncond, bus6.iord, bus6.mem_read, bus6.mem_write,
             bus6.ir_write, bus6.reg_write, bus6.reg_dst, bus6.mem_to_reg, bus6.jal, bus6.ui,
             bus6.alu_src_a, bus6.illegal};
        return s;
    endfunction

    // Model: current state, and the remaining route of the instruction in flight.
    logic [3:0]  m_state = 4'd0;
    logic [11:0] m_route = 12'd0;
    int          m_len = 0;
    int          m_idx = 0;
    logic [13:0] r_now;
    assign r_now = route(op);

    always @(posedge clk) begin
        if (rst) begin
            m_state <= 4'd0;
        end else if ((m_state == 4'd0 || m_state == 4'd3 || m_state == 4'd5) && !rdy_eff) begin
            m_state <= m_state;
        end else if (m_state == 4'd0) begin
            m_state <= 4'd1;
        end else if (m_state == 4'd1) begin
            m_route <= r_now[11:0];
            m_len   <= int'(r_now[13:12]);
            m_idx   <= 1;
            m_state <= (r_now[13:12] == 2'd0) ? 4'd0 : r_now[3:0];
        end else if (m_idx < m_len) begin
            m_state <= m_route[m_idx*4 +: 4];
            m_idx   <= m_idx + 1;
        end else begin
            m_state <= 4'd0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        outs_t e;
        e = exp_out(rst, m_state, op, rdy_eff);
        chk("cycle_dut4", 32'(sample4()), 32'(e));
        chk("cycle_dut6", 32'(sample6()), 32'(e));
    end

    outs_t trace[$];
    outs_t trace6[$];

    // Runs one instruction from FETCH until the DUT is back in FETCH (or reset aborts it).
    task automatic run_instr(input logic [5:0] o, input logic [31:0] rdy_pat, input int abort_at);
        trace.delete();
        trace6.delete();
        for (int i = 0; i < 20; i++) begin
            if (i > 0 && (rst || (bus4.state == 4'd0 && trace[$].state != 4'd0))) return;
            rst = (i == abort_at);
            op = o;
            mem_ready = rdy_pat[i];
            @(negedge clk);
            trace.push_back(sample4());
            trace6.push_back(sample6());
            @(posedge clk);
            #1;
        end
        chk("run_timeout", 32'd1, 32'd0);
    endtask

    task automatic chk_seq(input string name, input int e[$]);
        logic ok;
        string got;
        ok = (trace.size() == e.size());
        got = "";
        foreach (trace[i]) begin
            got = $sformatf("%s%0d ", got, trace[i].state);
            if (i < e.size() && int'(trace[i].state) != e[i]) ok = 1'b0;
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got states %s expected %p", name, got, e);
        end
    endtask

    initial begin
        int e[$];
        int cnt;
        logic [5:0] more_ops [9] = '{6'h0F, 6'h09, 6'h0D, 6'h0E, 6'h0A, 6'h0B, 6'h04, 6'h02, 6'h20};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs_zero", 32'(sample4()), 32'd0);
        @(posedge clk);
        #1;

        run_instr(6'h00, 32'hFFFF_FFFF, -1);
        e = '{0, 1, 6, 7};
        chk_seq("rtype_seq", e);
        chk("rtype_aluop_exec", 32'(trace[2].alu_op), 32'd2);
        chk("rtype_rwb_regdst_regwrite", {30'd0, trace[3].reg_dst, trace[3].reg_write}, 32'd3);
        chk("rtype_no_early_regwrite", 32'(trace[0].reg_write | trace[1].reg_write | trace[2].reg_write), 32'd0);

        run_instr(6'h23, 32'hFFFF_FFE7, -1);
`ifdef MULTICYCLE_CONTROL_STALL_EN
        e = '{0, 1, 2, 3, 3, 3, 4};
`else
        e = '{0, 1, 2, 3, 4};
`endif
        chk_seq("lw_wait_seq", e);
        cnt = 0;
        foreach (trace[i]) if (trace[i].state == 4'd3 && trace[i].mem_read && trace[i].iord) cnt++;
`ifdef MULTICYCLE_CONTROL_STALL_EN
        chk("lw_memrd_read_iord_cycles", 32'(cnt), 32'd3);
`else
        chk("lw_memrd_read_iord_cycles", 32'(cnt), 32'd1);
`endif

        run_instr(6'h05, 32'hFFFF_FFFF, -1);
        e = '{0, 1, 10};
        chk_seq("bne_seq", e);
        chk("bne_branch_ctrl", {26'd0, trace[2].pc_write_ncond, trace[2].pc_write_cond,
                                trace[2].pc_source, trace[2].alu_op[1:0]}, 32'b100101);

        run_instr(6'h0C, 32'hFFFF_FFFF, -1);
        e = '{0, 1, 8, 9};
        chk_seq("andi_seq", e);
        chk("andi_aluop6", 32'(trace6[2].alu_op), 32'b000101);
        chk("andi_ui_iexec_iwb", {30'd0, trace6[2].ui, trace6[3].ui}, 32'd3);

        run_instr(6'h03, 32'hFFFF_FFFF, -1);
        e = '{0, 1, 12};
        chk_seq("jal_seq", e);
        chk("jal_ctrl", {29'd0, trace[2].jal, trace[2].reg_write, trace[2].pc_write}, 32'd7);

        run_instr(6'h3F, 32'hFFFF_FFFF, -1);
        e = '{0, 1};
        chk_seq("illegal_seq", e);
        chk("illegal_pulse", {30'd0, trace[0].illegal, trace[1].illegal}, 32'd1);

        run_instr(6'h2B, 32'hFFFF_FFFE, -1);
`ifdef MULTICYCLE_CONTROL_STALL_EN
        e = '{0, 0, 1, 2, 5};
`else
        e = '{0, 1, 2, 5};
`endif
        chk_seq("sw_fetchwait_seq", e);

        run_instr(6'h23, 32'hFFFF_FFF7, 4);
        chk("abort_outputs_zero", 32'(trace[4]), 32'd0);
        cnt = 0;
        foreach (trace[i]) if (trace[i].reg_write) cnt++;
        chk("abort_no_regwrite", 32'(cnt), 32'd0);

        run_instr(6'h00, 32'hFFFF_FFFF, -1);
        chk("post_reset_fetch", 32'(trace[0].state), 32'd0);

        foreach (more_ops[k]) run_instr(more_ops[k], 32'hFFFF_FFFF, -1);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
